// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, the zero register and the MULDIV queue entry layout
package mips_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;
  typedef struct packed {
    logic              live;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;
endpackage

// File: rtl/wb_result_fifo.sv
// wb_result_fifo: DEPTH-entry circular queue of MULDIV results with kill-by-rd and match-by-rd
//   push/push_entry -> store at tail; pop -> advance head; full/empty/head -> queue state
//   kill/kill_rd    -> mark every live entry with that rd dead (including one pushed this cycle)
//   match_rd/match  -> some live entry targets match_rd
module wb_result_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  entry_t            push_entry,
  input  logic              pop,
  input  logic              kill,
  input  logic [ADDR_W-1:0] kill_rd,
  input  logic [ADDR_W-1:0] match_rd,
  output logic              full,
  output logic              empty,
  output entry_t            head,
  output logic              match
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  entry_t mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
  assign head  = mem[rd_ptr];
  // Popped slots are cleared to dead, so live implies occupied.
  always_comb begin
    match = 1'b0;
    for (int i = 0; i < DEPTH; i++) match = match | (mem[i].live && mem[i].rd == match_rd);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) if (kill && mem[i].rd == kill_rd) mem[i].live <= 1'b0;
      if (pop) begin
        mem[rd_ptr].live <= 1'b0;
        rd_ptr <= nxt(rd_ptr);
      end
      if (push) begin
        mem[wr_ptr] <= '{live: push_entry.live && !(kill && push_entry.rd == kill_rd),
                         rd: push_entry.rd, data: push_entry.data};
        wr_ptr <= nxt(wr_ptr);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: arbitrates the register-file write port between WB (priority) and queued MULDIV results
//   wb_*            -> in-order WB write request
//   md_*            -> MULDIV result handshake (md_ready = queue not full)
//   query_*         -> decode check for a live queued destination
//   stall_req       -> queue full or head starved for MAX_WAIT cycles
//   rf_we/waddr/wdata -> registered register-file write port
module rf_write_arbiter
  import mips_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_regWrite,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              md_valid,
  output logic              md_ready,
  input  logic [ADDR_W-1:0] md_rd,
  input  logic [DATA_W-1:0] md_data,
  input  logic [ADDR_W-1:0] query_rd,
  output logic              query_pending,
  output logic              stall_req,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  logic full, empty, match, wb_grant, pop, push, md_write;
  entry_t head, md_entry;
  logic [WW-1:0] wait_cnt;
  assign wb_grant      = wb_regWrite && wb_rd != REG_ZERO;
  assign pop           = !wb_grant && !empty;
  assign md_write      = pop && head.live;
  assign md_ready      = !full;
  assign push          = md_valid && md_ready && md_rd != REG_ZERO;
  assign md_entry      = '{live: 1'b1, rd: md_rd, data: md_data};
  assign stall_req     = full || wait_cnt >= WW'(MAX_WAIT);
  assign query_pending = query_rd != REG_ZERO && match;
  wb_result_fifo #(.DEPTH(DEPTH)) fifo (
    .clk(clk), .rst(rst), .push(push), .push_entry(md_entry), .pop(pop),
    .kill(wb_grant), .kill_rd(wb_rd), .match_rd(query_rd),
    .full(full), .empty(empty), .head(head), .match(match)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      wait_cnt <= '0;
    end else begin
      rf_we    <= wb_grant || md_write;
      rf_waddr <= wb_grant ? wb_rd : md_write ? head.rd : rf_waddr;
      rf_wdata <= wb_grant ? wb_data : md_write ? head.data : rf_wdata;
      wait_cnt <= empty || pop ? '0 : head.live && wait_cnt < WW'(MAX_WAIT) ? wait_cnt + 1'b1 : wait_cnt;
    end
  end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed spec scenarios plus random traffic against a queue-based reference model
module tb_rf_write_arbiter;
  localparam int DEPTH = 2, MAX_WAIT = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic wb_regWrite = 0, md_valid = 0;
  logic [4:0] wb_rd = 0, md_rd = 0, query_rd = 0;
  logic [31:0] wb_data = 0, md_data = 0;
  logic md_ready, query_pending, stall_req, rf_we;
  logic [4:0] rf_waddr;
  logic [31:0] rf_wdata;
  rf_write_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .wb_regWrite(wb_regWrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .md_valid(md_valid), .md_ready(md_ready), .md_rd(md_rd), .md_data(md_data),
    .query_rd(query_rd), .query_pending(query_pending), .stall_req(stall_req),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );
  always #5 clk = ~clk;
  typedef struct {bit live; logic [4:0] rd; logic [31:0] data;} ment_t;
  ment_t q[$];
  int wcnt = 0, n_cmp = 0, n_bad = 0;
  logic exp_we = 0;
  logic [4:0] exp_addr = 0;
  logic [31:0] exp_data = 0;
  logic [31:0] regs [32];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask
  function automatic bit pend(input logic [4:0] r);
    if (r == 0) return 0;
    foreach (q[i]) if (q[i].live && q[i].rd == r) return 1;
    return 0;
  endfunction
  task automatic do_reset();
    @(negedge clk);
    rst = 1; wb_regWrite = 0; md_valid = 0; query_rd = 5'd3;
    @(posedge clk); #1;
    q.delete(); wcnt = 0; exp_we = 0;
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_waddr", rf_waddr, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_md_ready", md_ready, 1);
    chk("rst_stall_req", stall_req, 0);
    chk("rst_query_pending", query_pending, 0);
    rst = 0;
  endtask
  task automatic cyc(input logic wr, input logic [4:0] wrd, input logic [31:0] wd,
                     input logic mv, input logic [4:0] mrd, input logic [31:0] mdd, input logic [4:0] qr);
    bit wbg, had, hlive, rdy, popped;
    ment_t e;
    @(negedge clk);
    rst = 0; wb_regWrite = wr; wb_rd = wrd; wb_data = wd;
    md_valid = mv; md_rd = mrd; md_data = mdd; query_rd = qr;
    #1;
    chk("md_ready", md_ready, q.size() < DEPTH);
    chk("stall_req", stall_req, q.size() == DEPTH || wcnt >= MAX_WAIT);
    chk("query_pending", query_pending, pend(qr));
    wbg = wr && wrd != 0;
    had = q.size() > 0;
    hlive = had && q[0].live;
    rdy = q.size() < DEPTH;
    popped = 0;
    if (wbg) begin
      exp_we = 1; exp_addr = wrd; exp_data = wd;
    end else if (had) begin
      e = q.pop_front(); popped = 1; exp_we = e.live;
      if (e.live) begin exp_addr = e.rd; exp_data = e.data; end
    end else exp_we = 0;
    wcnt = (!had || popped) ? 0 : (hlive && wcnt < MAX_WAIT) ? wcnt + 1 : wcnt;
    if (mv && rdy && mrd != 0) q.push_back('{1'b1, mrd, mdd});
    if (wbg) foreach (q[i]) if (q[i].rd == wrd) q[i].live = 0;
    @(posedge clk); #1;
    chk("rf_we", rf_we, exp_we);
    if (exp_we) begin
      chk("rf_waddr", rf_waddr, exp_addr);
      chk("rf_wdata", rf_wdata, exp_data);
    end
    if (rf_we) regs[rf_waddr] = rf_wdata;
  endtask
  task automatic idle(input int n, input logic [4:0] qr);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, qr);
  endtask
  initial begin
    foreach (regs[i]) regs[i] = 0;
    do_reset();
    cyc(1, 8, 32'hDEAD, 0, 0, 0, 0);
    chk("t1_r8", regs[8], 32'hDEAD);
    cyc(0, 0, 0, 1, 3, 32'h1234, 3);
    idle(1, 3);
    chk("t2_r3", regs[3], 32'h1234);
    cyc(1, 10, 32'hA, 1, 4, 32'h44, 4);
    cyc(1, 11, 32'hB, 1, 5, 32'h55, 5);
    cyc(1, 12, 32'hC, 0, 0, 0, 4);
    idle(3, 5);
    chk("t3_r4", regs[4], 32'h44);
    chk("t3_r5", regs[5], 32'h55);
    cyc(0, 0, 0, 1, 6, 32'h66, 6);
    cyc(1, 6, 32'hAA, 0, 0, 0, 6);
    idle(3, 6);
    chk("t4_r6", regs[6], 32'hAA);
    cyc(1, 9, 32'h90, 1, 7, 32'h77, 7);
    for (int i = 0; i < 6; i++) cyc(1, 9, 32'h91 + i, 0, 0, 0, 7);
    idle(2, 7);
    chk("t5_r7", regs[7], 32'h77);
    cyc(1, 14, 32'hE, 1, 13, 32'hD13, 13);
    cyc(1, 0, 32'hBAD, 1, 0, 32'hBAD0, 0);
    idle(1, 13);
    chk("t6_r13", regs[13], 32'hD13);
    chk("t6_r0", regs[0], 0);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(99) == 0) do_reset();
      else cyc($urandom_range(9) < 6, 5'($urandom_range(7)), $urandom,
               $urandom_range(1), 5'($urandom_range(7)), $urandom, 5'($urandom_range(7)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
